// File: rtl/tick_gen.sv
// Programmable periodic / one-shot tick generator with shadowed period register.
// Optional prescaler stage enabled by defining TICK_GEN_PRESCALER_EN.
module tick_gen #(
  parameter int WIDTH          = 16,
  parameter int DEFAULT_PERIOD = 10,
  parameter int TICK_CNT_W     = 8,
  parameter int PRESCALE       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic                  period_wr,
  input  logic [WIDTH-1:0]      period_in,
  output logic                  tick,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [TICK_CNT_W-1:0] tick_count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(DEFAULT_PERIOD);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("tick_gen: PRESCALE must be at least 2");
  end

  state_t                  state, state_next;
  logic [WIDTH-1:0]        count_next;
  logic [WIDTH-1:0]        shadow, shadow_next;
  logic [WIDTH-1:0]        active, active_next;
  logic [WIDTH-1:0]        reload;
  logic [TICK_CNT_W-1:0]   tick_count_next;
  logic                    tick_next;
  logic                    mode_q, mode_next;
  logic                    advance;
  logic                    terminal;

  // A write in the same cycle as a reload takes effect immediately.
  assign reload   = period_wr ? period_in : shadow;
  assign terminal = (count == active);
  assign busy     = (state == RUN);

`ifdef TICK_GEN_PRESCALER_EN
  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc, presc_next;

  assign advance = (state == RUN) && enable && (presc == PS_LAST);

  always_comb begin
    presc_next = presc;
    if (stop || start) begin
      presc_next = '0;
    end else if ((state == RUN) && enable) begin
      presc_next = (presc == PS_LAST) ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else begin
      presc <= presc_next;
    end
  end
`else
  assign advance = (state == RUN) && enable;
`endif

  always_comb begin
    state_next      = state;
    count_next      = count;
    tick_count_next = tick_count;
    tick_next       = 1'b0;
    mode_next       = mode_q;
    active_next     = active;
    shadow_next     = period_wr ? period_in : shadow;

    // Priority: stop, then start/retrigger, then normal counting.
    if (stop) begin
      state_next = IDLE;
      count_next = '0;
    end else if (start) begin
      state_next      = RUN;
      count_next      = '0;
      tick_count_next = '0;
      mode_next       = mode;
      active_next     = reload;
    end else if (advance) begin
      if (terminal) begin
        count_next      = '0;
        tick_next       = 1'b1;
        tick_count_next = tick_count + 1'b1;
        active_next     = reload;
        if (mode_q) begin
          state_next = IDLE;
        end
      end else begin
        count_next = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      tick       <= 1'b0;
      tick_count <= '0;
      mode_q     <= 1'b0;
      shadow     <= PERIOD_RST;
      active     <= PERIOD_RST;
    end else begin
      state      <= state_next;
      count      <= count_next;
      tick       <= tick_next;
      tick_count <= tick_count_next;
      mode_q     <= mode_next;
      shadow     <= shadow_next;
      active     <= active_next;
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: a driver feeds directed and random stimulus into a
// behavioural model and queues expected outputs; a monitor compares every cycle.
module tb_tick_gen;

  localparam int WIDTH  = 16;
  localparam int TCW    = 8;
`ifdef TICK_GEN_PRESCALER_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode = 1'b0;
  logic             period_wr = 1'b0;
  logic [WIDTH-1:0] period_in = '0;
  logic             tick;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic [TCW-1:0]   tick_count;

  tick_gen #(
    .WIDTH(WIDTH), .DEFAULT_PERIOD(10), .TICK_CNT_W(TCW), .PRESCALE(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
    .mode(mode), .period_wr(period_wr), .period_in(period_in),
    .tick(tick), .busy(busy), .count(count), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit tick;
    bit busy;
    int count;
    int tcnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: elapsed enabled cycles in the current period; a period
  // spans (P+1)*PS enabled cycles and the visible count is elapsed / PS.
  bit m_run;
  bit m_one;
  int m_el;
  int m_per;
  int m_shadow;
  int m_ticks;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_one = 0; m_el = 0; m_per = 10; m_shadow = 10; m_ticks = 0;
  endtask

  task automatic model_step(input bit e, s, p, md, w, input int pin, output exp_t x);
    x.tick = 0;
    if (p) begin
      m_run = 0;
      m_el  = 0;
    end else if (s) begin
      m_run   = 1;
      m_el    = 0;
      m_ticks = 0;
      m_one   = md;
      m_per   = w ? pin : m_shadow;
    end else if (m_run && e) begin
      m_el++;
      if (m_el == (m_per + 1) * PS) begin
        x.tick = 1;
        m_el   = 0;
        m_ticks++;
        m_per  = w ? pin : m_shadow;
        if (m_one) m_run = 0;
      end
    end
    if (w) m_shadow = pin;
    x.busy  = m_run;
    x.count = m_el / PS;
    x.tcnt  = m_ticks % (1 << TCW);
  endtask

  task automatic step(input bit e, s, p, md, w, input int pin);
    exp_t x;
    @(negedge clk);
    enable    = e;
    start     = s;
    stop      = p;
    mode      = md;
    period_wr = w;
    period_in = WIDTH'(pin);
    model_step(e, s, p, md, w, pin, x);
    q.push_back(x);
  endtask

  task automatic idle_steps(input int n, input bit e);
    for (int i = 0; i < n; i++) step(e, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " tick"}, int'(tick), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " count"}, int'(count), 0);
    chk({tag, " tick_count"}, int'(tick_count), 0);
  endtask

  // Monitor: outputs are presented every cycle once the driver is active.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("tick", int'(tick), int'(x.tick));
        chk("busy", int'(busy), int'(x.busy));
        chk("count", int'(count), x.count);
        chk("tick_count", int'(tick_count), x.tcnt);
      end
    end
  end

  initial begin
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Periodic, P=3
    step(0, 0, 0, 0, 1, 3);
    step(1, 1, 0, 0, 0, 0);
    idle_steps(12, 1);
    step(1, 0, 1, 0, 0, 0);

    // One-shot, P=2 written together with start
    step(1, 1, 0, 1, 1, 2);
    idle_steps(13, 1);

    // Period update mid-period
    step(1, 1, 0, 0, 1, 3);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 5);
    idle_steps(22, 1);

    // Enable low at count 2, then start+stop together
    step(1, 1, 0, 0, 1, 4);
    idle_steps(2, 1);
    idle_steps(3, 0);
    idle_steps(8, 1);
    step(1, 1, 1, 0, 0, 0);
    idle_steps(3, 1);

    // Reset mid-run at count 2 of P=5
    step(1, 1, 0, 0, 1, 5);
    idle_steps(2 * PS, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("async reset");
    model_reset();
    @(negedge clk);
    check_reset_outputs("held reset");
    rst = 1'b1;
    idle_steps(4, 1);

    // Default period after reset, no write
    step(1, 1, 0, 0, 0, 0);
    idle_steps(24, 1);

    // P=0 and retrigger in RUN
    step(1, 1, 0, 0, 1, 0);
    idle_steps(6, 1);
    step(1, 0, 0, 0, 1, 6);
    idle_steps(3, 1);
    step(1, 1, 0, 0, 0, 0);
    idle_steps(10, 1);

    // tick_count wrap with P=0
    step(1, 1, 0, 0, 1, 0);
    idle_steps(300 * PS, 1);

    // Random traffic
    step(1, 1, 0, 0, 1, 2);
    for (int i = 0; i < 800; i++) begin
      step(bit'($urandom_range(0, 9) != 0),
           bit'($urandom_range(0, 29) == 0),
           bit'($urandom_range(0, 59) == 0),
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 6)));
    end
    step(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
